// File: rtl/agc_mon_timing_rx_if.sv
// rtl/agc_mon_timing_rx_if.sv - AGC monitor timing pins: timepulses and GOJAM in, start/stop out
interface agc_mon_timing_rx_if;
  logic [11:0] MT;
  logic        MGOJAM;
  logic        MSTRT;
  logic        MSTP;

  // AGC side: drives timepulses and GOJAM, receives start/stop
  modport master (output MT, output MGOJAM, input MSTRT, input MSTP);
  // Monitor side
  modport slave (input MT, input MGOJAM, output MSTRT, output MSTP);
endinterface

// File: rtl/agc_mon_timing_rx.sv
// rtl/agc_mon_timing_rx.sv - AGC monitor timing endpoint: MT order tracker, MCT counter, MSTRT/MSTP
module agc_mon_timing_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_CYC   = 250,
  parameter int TIMEOUT_CYC = 2048,
  parameter int CNT_W       = 32
) (
  input  logic                SIM_CLK,
  input  logic                SIM_RST,
  agc_mon_timing_rx_if.slave  agc,
  input  logic                start_req,
  input  logic                stop_set,
  input  logic                stop_clr,
  output logic [3:0]          tp_index,
  output logic                locked,
  output logic                mct_strobe,
  output logic [CNT_W-1:0]    mct_count,
  output logic                seq_err,
  output logic                gojam_seen,
  output logic                stalled
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam int PC_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

  typedef enum logic {HUNT, TRACK} trk_state_t;
  typedef enum logic {IDLE, PULSE} strt_state_t;

  trk_state_t  trk_state;
  strt_state_t strt_state;

  logic [12:0]     sync_q [SYNC_STAGES];
  logic [11:0]     mt_prev;
  logic [WD_W-1:0] wd;
  logic [PC_W-1:0] pulse_cnt;
  logic            start_prev;
  logic            mstrt_q;
  logic            mstp_q;

  logic [11:0] mt_s;
  logic        gojam_s;
  logic [11:0] mt_edge;
  logic        any_edge;
  logic        multi_hot;
  logic [3:0]  exp_tp;
  logic [11:0] exp_mask;
  logic        wd_hit;

  assign mt_s      = sync_q[SYNC_STAGES-1][11:0];
  assign gojam_s   = sync_q[SYNC_STAGES-1][12];
  assign mt_edge   = mt_s & ~mt_prev;
  assign any_edge  = |mt_edge;
  assign multi_hot = (mt_s & (mt_s - 12'd1)) != 12'd0;
  assign exp_tp    = (tp_index == 4'd12) ? 4'd1 : tp_index + 4'd1;
  assign exp_mask  = 12'd1 << (exp_tp - 4'd1);
  // Fires on the cycle the watchdog reaches its limit
  assign wd_hit    = !any_edge && (wd == WD_W'(TIMEOUT_CYC - 1));

  assign agc.MSTRT = mstrt_q;
  assign agc.MSTP  = mstp_q;

  // Synchronize MT and MGOJAM together and keep the previous sample for edge detect
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      mt_prev <= '0;
    end else begin
      sync_q[0] <= {agc.MGOJAM, agc.MT};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      mt_prev <= mt_s;
    end
  end

  // Watchdog: any MT edge restarts it; saturates at the limit and flags a stall
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      wd      <= '0;
      stalled <= 1'b0;
    end else if (any_edge) begin
      wd      <= '0;
      stalled <= 1'b0;
    end else if (wd != WD_W'(TIMEOUT_CYC)) begin
      wd <= wd + 1'b1;
      if (wd_hit) stalled <= 1'b1;
    end
  end

  // Timepulse tracker; GOJAM beats a stall, which beats normal sequencing
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      trk_state  <= HUNT;
      tp_index   <= 4'd0;
      locked     <= 1'b0;
      mct_strobe <= 1'b0;
      mct_count  <= '0;
      seq_err    <= 1'b0;
      gojam_seen <= 1'b0;
    end else begin
      mct_strobe <= 1'b0;
      if (gojam_s) begin
        trk_state  <= HUNT;
        tp_index   <= 4'd0;
        locked     <= 1'b0;
        gojam_seen <= 1'b1;
      end else if (wd_hit) begin
        trk_state <= HUNT;
        tp_index  <= 4'd0;
        locked    <= 1'b0;
      end else begin
        case (trk_state)
          HUNT: begin
            if (mt_edge == 12'h001 && !multi_hot) begin
              trk_state <= TRACK;
              tp_index  <= 4'd1;
              locked    <= 1'b1;
              mct_count <= '0;
            end
          end
          TRACK: begin
            if (multi_hot || (any_edge && mt_edge != exp_mask)) begin
              seq_err   <= 1'b1;
              trk_state <= HUNT;
              tp_index  <= 4'd0;
              locked    <= 1'b0;
            end else if (any_edge) begin
              tp_index <= exp_tp;
              if (exp_tp == 4'd1) begin
                mct_strobe <= 1'b1;
                mct_count  <= mct_count + 1'b1;
              end
            end
          end
          default: trk_state <= HUNT;
        endcase
      end
    end
  end

  // MSTRT generator: one fixed-width pulse per start_req rising edge, no queueing
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      strt_state <= IDLE;
      start_prev <= 1'b0;
      pulse_cnt  <= '0;
      mstrt_q    <= 1'b0;
    end else begin
      start_prev <= start_req;
      case (strt_state)
        IDLE: begin
          if (start_req && !start_prev) begin
            strt_state <= PULSE;
            pulse_cnt  <= '0;
            mstrt_q    <= 1'b1;
          end
        end
        PULSE: begin
          if (pulse_cnt == PC_W'(PULSE_CYC - 1)) begin
            strt_state <= IDLE;
            mstrt_q    <= 1'b0;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
        default: strt_state <= IDLE;
      endcase
    end
  end

  // MSTP level: set/clear, simultaneous request holds
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) mstp_q <= 1'b0;
    else if (stop_set && !stop_clr) mstp_q <= 1'b1;
    else if (stop_clr && !stop_set) mstp_q <= 1'b0;
  end

endmodule

// File: tb/tb_agc_mon_timing_rx.sv
// tb/tb_agc_mon_timing_rx.sv - directed bench for agc_mon_timing_rx
module tb_agc_mon_timing_rx;

  logic SIM_CLK = 1'b0;
  logic SIM_RST = 1'b1;
  logic start_req = 1'b0;
  logic stop_set = 1'b0;
  logic stop_clr = 1'b0;

  agc_mon_timing_rx_if ifc ();
  agc_mon_timing_rx_if ifc4 ();

  logic [3:0]  tp_index, tp_index4;
  logic        locked, locked4, mct_strobe, mct_strobe4;
  logic [31:0] mct_count;
  logic [3:0]  mct_count4;
  logic        seq_err, seq_err4, gojam_seen, gojam_seen4, stalled, stalled4;

  int n_cmp = 0;
  int n_err = 0;
  int strobe_cnt = 0;

  always #10 SIM_CLK = ~SIM_CLK;

  assign ifc4.MT     = ifc.MT;
  assign ifc4.MGOJAM = ifc.MGOJAM;

  agc_mon_timing_rx dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .agc(ifc),
    .start_req(start_req), .stop_set(stop_set), .stop_clr(stop_clr),
    .tp_index(tp_index), .locked(locked), .mct_strobe(mct_strobe),
    .mct_count(mct_count), .seq_err(seq_err), .gojam_seen(gojam_seen),
    .stalled(stalled)
  );

  agc_mon_timing_rx #(.CNT_W(4)) dut4 (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .agc(ifc4),
    .start_req(start_req), .stop_set(stop_set), .stop_clr(stop_clr),
    .tp_index(tp_index4), .locked(locked4), .mct_strobe(mct_strobe4),
    .mct_count(mct_count4), .seq_err(seq_err4), .gojam_seen(gojam_seen4),
    .stalled(stalled4)
  );

  always @(negedge SIM_CLK) if (mct_strobe === 1'b1) strobe_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge SIM_CLK);
    #1;
  endtask

  task automatic do_reset();
    SIM_RST = 1'b1;
    ifc.MT = '0;
    ifc.MGOJAM = 1'b0;
    start_req = 1'b0;
    stop_set = 1'b0;
    stop_clr = 1'b0;
    tick(3);
    SIM_RST = 1'b0;
  endtask

  task automatic mt_pulse(input int idx, input int cyc);
    ifc.MT = 12'd1 << (idx - 1);
    tick(cyc);
  endtask

  task automatic mct_seq();
    for (int i = 1; i <= 12; i++) mt_pulse(i, 50);
  endtask

  initial begin
    int s0, hi_cnt, rise_cnt, wait_cnt;
    logic prev;

    // 1: reset state, latency, three full sequences
    ifc.MT = '0;
    ifc.MGOJAM = 1'b0;
    do_reset();
    check_eq("rst_mstrt", ifc.MSTRT, 0);
    check_eq("rst_mstp", ifc.MSTP, 0);
    check_eq("rst_tp", tp_index, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_count", mct_count, 0);
    check_eq("rst_flags", {seq_err, gojam_seen, stalled, mct_strobe}, 0);
    s0 = strobe_cnt;
    ifc.MT = 12'h001;
    tick(2);
    check_eq("lat_before", tp_index, 0);
    tick(1);
    check_eq("lat_at", tp_index, 1);
    check_eq("lock_first", locked, 1);
    tick(47);
    for (int i = 2; i <= 12; i++) mt_pulse(i, 50);
    mct_seq();
    mct_seq();
    check_eq("t1_count", mct_count, 2);
    check_eq("t1_strobes", strobe_cnt - s0, 2);
    check_eq("t1_seq_err", seq_err, 0);
    check_eq("t1_tp12", tp_index, 12);

    // 2: out-of-order MT07 at tp 5, then relock
    for (int i = 1; i <= 5; i++) mt_pulse(i, 50);
    check_eq("t2_tp5", tp_index, 5);
    check_eq("t2_count3", mct_count, 3);
    mt_pulse(7, 50);
    check_eq("t2_seq_err", seq_err, 1);
    check_eq("t2_unlock", locked, 0);
    check_eq("t2_tp0", tp_index, 0);
    for (int i = 8; i <= 12; i++) mt_pulse(i, 50);
    check_eq("t2_hunt", locked, 0);
    mt_pulse(1, 50);
    check_eq("t2_relock", locked, 1);
    check_eq("t2_cnt0", mct_count, 0);
    for (int i = 2; i <= 12; i++) mt_pulse(i, 50);
    mt_pulse(1, 50);
    check_eq("t2_cnt1", mct_count, 1);

    // 3: GOJAM for 3 us mid-MCT
    do_reset();
    mct_seq();
    for (int i = 1; i <= 4; i++) mt_pulse(i, 50);
    check_eq("t3_pre_lock", locked, 1);
    ifc.MGOJAM = 1'b1;
    for (int i = 5; i <= 7; i++) mt_pulse(i, 50);
    check_eq("t3_gojam", gojam_seen, 1);
    check_eq("t3_unlock", locked, 0);
    check_eq("t3_no_err", seq_err, 0);
    check_eq("t3_tp0", tp_index, 0);
    ifc.MGOJAM = 1'b0;
    for (int i = 8; i <= 12; i++) mt_pulse(i, 50);
    check_eq("t3_still_hunt", locked, 0);
    mt_pulse(1, 50);
    check_eq("t3_relock", locked, 1);
    check_eq("t3_gojam_sticky", gojam_seen, 1);

    // 4: MSTP set/clear, MSTRT pulse width, async reset mid-pulse
    stop_set = 1'b1; tick(1); stop_set = 1'b0; tick(1);
    check_eq("mstp_set", ifc.MSTP, 1);
    stop_set = 1'b1; stop_clr = 1'b1; tick(1); stop_set = 1'b0; stop_clr = 1'b0; tick(1);
    check_eq("mstp_hold1", ifc.MSTP, 1);
    stop_clr = 1'b1; tick(1); stop_clr = 1'b0; tick(1);
    check_eq("mstp_clr", ifc.MSTP, 0);
    stop_set = 1'b1; stop_clr = 1'b1; tick(1); stop_set = 1'b0; stop_clr = 1'b0; tick(1);
    check_eq("mstp_hold0", ifc.MSTP, 0);

    start_req = 1'b1;
    hi_cnt = 0; rise_cnt = 0; prev = 1'b0;
    for (int k = 0; k < 600; k++) begin
      tick(1);
      if (k == 500) start_req = 1'b0;
      if (ifc.MSTRT === 1'b1) hi_cnt++;
      if (ifc.MSTRT === 1'b1 && !prev) rise_cnt++;
      prev = ifc.MSTRT;
    end
    check_eq("mstrt_width", hi_cnt, 250);
    check_eq("mstrt_single", rise_cnt, 1);

    start_req = 1'b1;
    wait_cnt = 0;
    while (ifc.MSTRT !== 1'b1 && wait_cnt < 10) begin
      tick(1);
      wait_cnt++;
    end
    check_eq("mstrt_start", ifc.MSTRT, 1);
    tick(100);
    check_eq("mstrt_mid", ifc.MSTRT, 1);
    #4;
    SIM_RST = 1'b1;
    #1;
    check_eq("mstrt_async_rst", ifc.MSTRT, 0);
    tick(2);
    start_req = 1'b0;
    SIM_RST = 1'b0;

    // 5: watchdog stall and recovery
    do_reset();
    for (int i = 1; i <= 3; i++) mt_pulse(i, 50);
    check_eq("t5_lock", locked, 1);
    tick(1900);
    check_eq("t5_not_yet", stalled, 0);
    tick(200);
    check_eq("t5_stalled", stalled, 1);
    check_eq("t5_unlock", locked, 0);
    ifc.MT = 12'h001;
    tick(5);
    check_eq("t5_unstall", stalled, 0);
    check_eq("t5_relock", locked, 1);
    check_eq("t5_tp1", tp_index, 1);

    // 6: 17 MCTs, narrow counter wraps
    do_reset();
    for (int s = 1; s <= 18; s++) begin
      mct_seq();
      if (s == 16) check_eq("t6_cnt15", mct_count4, 15);
      if (s == 17) check_eq("t6_wrap0", mct_count4, 0);
    end
    check_eq("t6_cnt4_end", mct_count4, 1);
    check_eq("t6_cnt32_end", mct_count, 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
